core_mem_arbiter: RTL and testbench

//  Shares the single core memory bus between the instruction-fetch requester (read-only) and the

---
 rtl/core_mem_arbiter_if.sv | 49 ++++
 rtl/core_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// Requester-side and memory-bus-side signal bundle for core_mem_arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/bus view.
interface core_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;

  // data load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_strb;
  logic              d_ack;

  // shared completion path
  logic [DATA_W-1:0] rdata;
  logic              err;

  // memory bus
  logic              m_valid;
  logic              m_ready;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_strb;
  logic              m_resp;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_strb,
    input  m_ready, m_resp, m_rdata,
    output i_ack, d_ack, rdata, err,
    output m_valid, m_we, m_addr, m_wdata, m_strb
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_strb,
    output m_ready, m_resp, m_rdata,
    input  i_ack, d_ack, rdata, err,
    input  m_valid, m_we, m_addr, m_wdata, m_strb
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing the core memory bus between instruction fetch and data access.
// One transaction at a time: IDLE -> REQ -> RESP -> DONE, with an optional response timeout.
module core_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               NRST,
  core_mem_arbiter_if.master bus
);
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam bit          TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    G_INSTR = 1'b0,
    G_DATA  = 1'b1
  } grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              m_valid_q, m_valid_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0] m_strb_q, m_strb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;

  logic              pick_data;
  logic              timeout_hit;
  logic              complete;
  logic              abort;

  // grant_q doubles as "last granted": a tie goes to whoever did not win last time
  assign pick_data   = bus.d_req && (!bus.i_req || (grant_q == G_INSTR));
  assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_strb_d  = m_strb_q;
    rdata_d   = rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d   = S_REQ;
          m_valid_d = 1'b1;
          cnt_d     = '0;
          if (pick_data) begin
            grant_d   = G_DATA;
            m_we_d    = bus.d_we;
            m_addr_d  = bus.d_addr;
            m_wdata_d = bus.d_wdata;
            m_strb_d  = bus.d_strb;
          end else begin
            grant_d   = G_INSTR;
            m_we_d    = 1'b0;
            m_addr_d  = bus.i_addr;
            m_wdata_d = '0;
            m_strb_d  = '1;
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          abort = 1'b1;
        end else if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = S_RESP;
        end
      end

      // a response landing in the final allowed cycle still completes normally
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.m_resp) begin
          complete = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // both completion paths converge on DONE with a one-cycle ACK to the owner
    if (complete || abort) begin
      state_d   = S_DONE;
      m_valid_d = 1'b0;
      err_d     = abort;
      i_ack_d   = (grant_q == G_INSTR);
      d_ack_d   = (grant_q == G_DATA);
      if (abort) begin
        rdata_d = '0;
      end else if (!m_we_q) begin
        rdata_d = bus.m_rdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q   <= S_IDLE;
      grant_q   <= G_DATA;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_strb_q  <= '0;
      rdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_strb_q  <= m_strb_d;
      rdata_q   <= rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.m_strb  = m_strb_q;
  assign bus.rdata   = rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Randomized self-checking bench for core_mem_arbiter against a transaction-level model.
// The model predicts grant order, bus contents, ACK cycle, RDATA and ERR from the timing rules.
module tb_core_mem_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned TIMEOUT = 8;

  logic CLK  = 1'b0;
  logic NRST = 1'b0;
  always #5 CLK = ~CLK;

  core_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  core_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK (CLK),
    .NRST(NRST),
    .bus (bus)
  );

  int n_run;
  int n_fail;

  // reference model state: pending requests, their payloads, fairness and read-data history
  bit                pi, pd, dwe;
  logic [ADDR_W-1:0] ia, da;
  logic [DATA_W-1:0] dwd;
  logic [STRB_W-1:0] dst;
  bit                last_d;
  logic [DATA_W-1:0] rdata_exp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_reqs();
    bus.i_req   = pi;
    bus.i_addr  = ia;
    bus.d_req   = pd;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    bus.d_strb  = dst;
  endtask

  task automatic new_i();
    pi = 1'b1;
    ia = ADDR_W'($urandom) & ~ADDR_W'(3);
  endtask

  task automatic new_d();
    pd  = 1'b1;
    dwe = 1'($urandom);
    da  = ADDR_W'($urandom);
    dwd = DATA_W'($urandom);
    dst = STRB_W'($urandom);
  endtask

  task automatic check_idle();
    check_eq("idle_m_valid", bus.m_valid, 1'b0);
    check_eq("idle_i_ack", bus.i_ack, 1'b0);
    check_eq("idle_d_ack", bus.d_ack, 1'b0);
    check_eq("idle_err", bus.err, 1'b0);
    check_eq("idle_rdata", bus.rdata, rdata_exp);
  endtask

  task automatic do_reset();
    NRST        = 1'b0;
    pi          = 1'b0;
    pd          = 1'b0;
    drive_reqs();
    bus.m_ready = 1'b0;
    bus.m_resp  = 1'b0;
    bus.m_rdata = '0;
    step();
    step();
    check_eq("rst_m_valid", bus.m_valid, 1'b0);
    check_eq("rst_m_we", bus.m_we, 1'b0);
    check_eq("rst_m_addr", bus.m_addr, '0);
    check_eq("rst_m_wdata", bus.m_wdata, '0);
    check_eq("rst_m_strb", bus.m_strb, '0);
    check_eq("rst_i_ack", bus.i_ack, 1'b0);
    check_eq("rst_d_ack", bus.d_ack, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_rdata", bus.rdata, '0);
    NRST      = 1'b1;
    last_d    = 1'b1;
    rdata_exp = '0;
  endtask

  // Called in an IDLE cycle with requests already driven. rd = stall cycles before M_READY,
  // sd = cycles between acceptance and M_RESP, never = no response at all.
  task automatic run_txn(input int rd, input int sd, input bit never, input bit drop,
                         input logic [DATA_W-1:0] rval);
    bit gd;
    bit normal;
    bit exp_v;
    int ack_k;
    gd     = pd && (!pi || !last_d);
    normal = !never && (rd + sd + 2 <= int'(TIMEOUT));
    ack_k  = normal ? rd + sd + 3 : int'(TIMEOUT) + 1;
    for (int k = 1; k <= ack_k; k++) begin
      step();
      exp_v = (k <= rd + 1) && (k < ack_k);
      check_eq("m_valid", bus.m_valid, exp_v);
      if (exp_v) begin
        check_eq("m_addr", bus.m_addr, gd ? da : ia);
        check_eq("m_we", bus.m_we, gd ? dwe : 1'b0);
        check_eq("m_strb", bus.m_strb, gd ? dst : {STRB_W{1'b1}});
        if (gd && dwe) check_eq("m_wdata", bus.m_wdata, dwd);
      end
      check_eq("i_ack", bus.i_ack, (k == ack_k) && !gd);
      check_eq("d_ack", bus.d_ack, (k == ack_k) && gd);
      check_eq("err", bus.err, (k == ack_k) && !normal);
      if (k == ack_k) begin
        if (!normal) rdata_exp = '0;
        else if (!(gd && dwe)) rdata_exp = rval;
        check_eq("ack_rdata", bus.rdata, rdata_exp);
      end
      bus.m_ready = (k == rd + 1);
      bus.m_resp  = (k <= rd + 1) ? 1'($urandom) : 1'(!never && (k == rd + sd + 2));
      bus.m_rdata = (k == rd + sd + 2) ? rval : DATA_W'($urandom);
      if (drop && k == 1) begin
        if (gd) bus.d_req = 1'b0;
        else    bus.i_req = 1'b0;
      end
    end
    bus.m_ready = 1'b0;
    bus.m_resp  = 1'b0;
    last_d      = gd;
    if (gd) pd = 1'b0;
    else    pi = 1'b0;
  endtask

  // From the ACK cycle: release the served requester and move into the following IDLE cycle.
  task automatic next_round();
    drive_reqs();
    step();
    check_idle();
  endtask

  initial begin
    int rd;
    int sd;
    bit never;
    bit drop;
    n_run  = 0;
    n_fail = 0;
    ia     = '0;
    da     = '0;
    dwd    = '0;
    dwe    = 1'b0;
    dst    = '0;
    do_reset();

    // single instruction fetch, minimum latency
    pi = 1'b1;
    ia = 32'h100;
    drive_reqs();
    run_txn(0, 0, 1'b0, 1'b0, 32'h0050_0093);
    next_round();

    // store stalled four cycles by M_READY; RDATA keeps the fetched word
    pd  = 1'b1;
    dwe = 1'b1;
    da  = 32'h2004;
    dwd = 32'hDEAD_BEEF;
    dst = 4'h3;
    drive_reqs();
    run_txn(4, 1, 1'b0, 1'b0, 32'h1111_1111);
    next_round();

    // both requesters from reset, each re-requesting right after its ACK
    do_reset();
    new_i();
    new_d();
    drive_reqs();
    for (int n = 0; n < 4; n++) begin
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, DATA_W'($urandom));
      next_round();
      if (last_d) new_d();
      else        new_i();
      drive_reqs();
    end
    run_txn(1, 1, 1'b0, 1'b0, DATA_W'($urandom));
    next_round();
    if (pi || pd) begin
      run_txn(0, 0, 1'b0, 1'b0, DATA_W'($urandom));
      next_round();
    end

    // load with no response: aborted by the timeout, then a late response is ignored
    pd  = 1'b1;
    dwe = 1'b0;
    da  = 32'h0000_3000;
    drive_reqs();
    run_txn(0, 0, 1'b1, 1'b0, 32'h0);
    next_round();
    bus.m_resp  = 1'b1;
    bus.m_rdata = 32'hBAD0_BAD0;
    step();
    check_idle();
    bus.m_resp = 1'b0;
    step();
    check_idle();

    // reset while waiting for the response abandons the transaction
    new_i();
    drive_reqs();
    step();
    check_eq("rr_m_valid_req", bus.m_valid, 1'b1);
    bus.m_ready = 1'b1;
    step();
    check_eq("rr_m_valid_resp", bus.m_valid, 1'b0);
    bus.m_ready = 1'b0;
    NRST        = 1'b0;
    pi          = 1'b0;
    drive_reqs();
    step();
    check_eq("rr_m_valid", bus.m_valid, 1'b0);
    check_eq("rr_i_ack", bus.i_ack, 1'b0);
    check_eq("rr_d_ack", bus.d_ack, 1'b0);
    NRST      = 1'b1;
    last_d    = 1'b1;
    rdata_exp = '0;
    step();
    check_idle();
    new_i();
    drive_reqs();
    run_txn(1, 1, 1'b0, 1'b0, DATA_W'($urandom));
    next_round();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if (!pi && !pd && ($urandom_range(0, 2) == 0)) begin
        step();
        check_idle();
      end
      if (!pi && $urandom_range(0, 1) == 1) new_i();
      if (!pd && ($urandom_range(0, 1) == 1 || !pi)) new_d();
      drive_reqs();
      rd    = $urandom_range(0, 4);
      sd    = $urandom_range(0, 5);
      never = ($urandom_range(0, 7) == 0);
      if (!never && (rd + sd + 2 == int'(TIMEOUT))) sd++;
      drop  = ($urandom_range(0, 3) == 0);
      run_txn(rd, sd, never, drop, DATA_W'($urandom));
      next_round();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $fatal(1);
  end
endmodule
